// File: rtl/sum_result_buffer.sv
// Result FIFO behind the one-cycle adder: buffers sums, presents them on a
// valid/ready port, and tracks a running total plus overflow/drop statistics.
module sum_result_buffer #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  parameter int ACC_W = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [ACC_W-1:0]           acc,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: the head is transferred at a rising edge where out_valid and
  // out_ready are both 1; out_data holds steady while out_valid && !out_ready.
  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;

  logic full, pop, push_ok, drop;

  assign full    = (count_q == CW'(DEPTH));
  assign pop     = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = in_valid && (!full || pop);
  assign drop    = in_valid && full && !pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      acc_d    = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        acc_d    = acc_q + ACC_W'(in_data);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push_ok) begin
        count_d = count_q - 1'b1;
      end
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign acc       = acc_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sum_result_buffer.sv
// Bench for sum_result_buffer: directed scenarios plus random traffic against
// a queue-based reference model; popped data is checked by a separate monitor.
module tb_sum_result_buffer;

  localparam int W     = 20;
  localparam int DEPTH = 4;
  localparam int ACC_W = 28;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    count;
  logic [ACC_W-1:0] acc;
  logic             overflow;
  logic [7:0]       drop_cnt;

  sum_result_buffer #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .acc(acc), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and reference model
  int               checks = 0;
  int               errors = 0;
  logic [W-1:0]     exp_q[$];
  logic [ACC_W-1:0] m_acc;
  logic             m_ovf;
  int               m_drop;
  logic [W-1:0]     mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_acc  = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_acc"}, 32'(acc), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  task automatic check_state();
    logic [W-1:0] head;
    head = '0;
    if (exp_q.size() != 0) head = exp_q[0];
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("out_data", 32'(out_data), 32'(head));
    chk("acc", 32'(acc), 32'(m_acc));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // driver: check current state, drive one cycle, advance the model
  task automatic step(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
    bit pop;
    check_state();
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    if (fl) begin
      model_clear();
    end else begin
      pop = (exp_q.size() != 0) && rdy;
      if (v) begin
        if (exp_q.size() < DEPTH || pop) begin
          exp_q.push_back(d);
          m_acc = m_acc + ACC_W'(d);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_zero("midrst");
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted head must match the oldest expected entry
  always @(negedge clk) begin
    if (rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got 0x%0h popped, expected no entry", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_data", 32'(out_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 20'h00123;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    rst      = 1'b0;
    in_valid = 1'b0;

    // single pass-through
    step(1'b1, 20'h003FF, 1'b1, 1'b0);
    chk("pt_valid", 32'(out_valid), 1);
    chk("pt_data", 32'(out_data), 32'h3FF);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pt_empty", 32'(out_valid), 0);
    chk("pt_acc", 32'(acc), 32'h3FF);
    step(1'b0, '0, 1'b0, 1'b1);

    // fill, order, pointer wrap
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(count), 4);
    chk("fill_head", 32'(out_data), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, W'(5), 1'b0, 1'b0);
    step(1'b1, W'(6), 1'b0, 1'b0);
    chk("wrap_count", 32'(count), 4);
    chk("wrap_head", 32'(out_data), 3);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_count", 32'(count), 0);
    chk("fill_acc", 32'(acc), 32'h15);

    // overflow and full push+pop boundary
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, W'(16 * i), 1'b0, 1'b0);
    step(1'b1, 20'hAAAAA, 1'b0, 1'b0);
    step(1'b1, 20'hAAAAA, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drops", 32'(drop_cnt), 2);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_acc", 32'(acc), 32'hA0);
    step(1'b1, 20'h00007, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 4);
    chk("fullpp_drops", 32'(drop_cnt), 2);
    chk("fullpp_acc", 32'(acc), 32'hA7);

    // flush beats same-cycle push and pop
    step(1'b0, '0, 1'b1, 1'b0);
    chk("preflush_count", 32'(count), 3);
    step(1'b1, 20'h00009, 1'b1, 1'b1);
    check_zero("flush");

    // drop counter saturation
    for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    repeat (260) step(1'b1, W'($urandom), 1'b0, 1'b0);
    chk("sat_drops", 32'(drop_cnt), 255);
    chk("sat_count", 32'(count), 4);
    step(1'b0, '0, 1'b0, 1'b1);

    // asynchronous reset mid-operation
    step(1'b1, 20'h00080, 1'b0, 1'b0);
    step(1'b1, 20'h00080, 1'b0, 1'b0);
    chk("prerst_count", 32'(count), 2);
    chk("prerst_acc", 32'(acc), 32'h100);
    reset_pulse();
    step(1'b1, 20'h00042, 1'b0, 1'b0);
    chk("postrst_valid", 32'(out_valid), 1);
    chk("postrst_data", 32'(out_data), 32'h42);
    chk("postrst_acc", 32'(acc), 32'h42);

    // random traffic
    repeat (400) begin
      step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) == 0);
    end
    repeat (DEPTH + 4) step(1'b0, '0, 1'b1, 1'b0);
    chk("final_count", 32'(count), 0);
    chk("final_valid", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
